cc2420_spi_ctrl: RTL
====================

# cc2420_spi_ctrl

Transaction sequencer between radio-control logic and the byte-level SPI engine driving the CC2420. It accepts one command at a time: strobe, 16-bit register write, or 16-bit register read. It expands each command into the CC2420 header/data byte sequence, streams the bytes to the SPI engine back-to-back so chip-select stays asserted, and collects the returned bytes. It returns the status byte, plus read data for reads.

## Interface
- `TIMEOUT`, default 1024: cycles allowed without SPI progress (byte accept or `NewData`) before a transfer is aborted; must be ≥ 2.
- `Clock`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `ReqValid`  in  1  command present.
- `ReqReady`  out  1  controller can accept a command; handshake when `ReqValid && ReqReady`.
- `ReqType`  in  2  00 strobe, 01 register write, 10 register read, 11 illegal.
- `ReqAddr`  in  6  CC2420 strobe/register address.
- `ReqWData`  in  16  write data, MSB sent first.
- `RespValid`  out  1  one-cycle pulse: command completed successfully.
- `RespData`  out  16  read data; valid with `RespValid` for reads, held until the next read completes.
- `Status`  out  8  CC2420 status byte from the last completed command; held.
- `Error`  out  1  one-cycle pulse: timeout abort or illegal `ReqType`.
- `Busy`  out  1  command in progress (`!ReqReady`).
- `SpiInValid`  out  1  to SPI `InValid`: byte on `SpiIn` offered.
- `SpiIn`  out  8  to SPI `In`.
- `SpiInRequest`  in  1  from SPI `InRequest`: byte accepted in any cycle where `SpiInValid && SpiInRequest`.
- `SpiNewData`  in  1  from SPI `NewData`: one-cycle pulse, `SpiOut` holds the received byte.
- `SpiOut`  in  8  from SPI `Out`.

## Operation
- **Byte sequences.** Header = {1'b0, RW, ReqAddr}, where RW = 1 for reads.
  - Strobe: 1 byte {2'b00, addr}.
  - Write: 3 bytes: header, `ReqWData[15:8]`, `ReqWData[7:0]`.
  - Read: 3 bytes: {2'b01, addr}, 8'h00, 8'h00.
- **SPI engine contract.** One `SpiNewData` per accepted byte, in order. Chip-select deasserts when no byte is offered at a request. The controller therefore keeps `SpiInValid` high continuously from the first to the last byte.
- **States.**
  - IDLE: `ReqReady` = 1. On handshake, latch type/addr/data. Go to XFER; for illegal type, go to ERR instead.
  - XFER: `SpiInValid` = (tx_cnt < len) and `SpiIn` = byte[tx_cnt]. tx_cnt increments on accept. rx_cnt increments on `SpiNewData`.
    - rx byte 0 → status shadow.
    - Read rx byte 1 → data[15:8]; read rx byte 2 → data[7:0].
    - When rx_cnt reaches len (including the cycle of the final `SpiNewData`), go to DONE.
  - DONE (1 cycle): `RespValid` = 1. `Status` updates; for reads, `RespData` updates. Return to IDLE.
  - ERR (1 cycle): `Error` = 1. `Status` and `RespData` unchanged. Return to IDLE.
- **Timeout.** The timer clears on entry to XFER and on every accept or `SpiNewData`. When it reaches `TIMEOUT`-1 in XFER, go to ERR. The SPI engine sees `SpiInValid` drop and ends the frame.
- **Boundary cases.**
  - `SpiNewData` arriving outside XFER is ignored.
  - `SpiNewData` beyond len is ignored.
  - Accept and `SpiNewData` in the same cycle: both counters advance.
  - Addresses are not range-checked.
  - `ReqValid` deasserting after the handshake has no effect.

## Timing
- **Reset values:** state IDLE, `ReqReady` 1, `Busy` 0, `RespValid` 0, `Error` 0, `SpiInValid` 0, `SpiIn` 8'h00, `Status` 8'h00, `RespData` 16'h0000. All counters 0.
- **Outputs** are registered state decodes. `SpiIn` and `SpiInValid` are valid in the first XFER cycle, which is the cycle after the handshake.
- **Byte streaming:** with `SpiInRequest` high, consecutive bytes are offered on consecutive accept cycles with no gap. The next byte appears the cycle after an accept.
- **Completion latency:** `RespValid` occurs 1 cycle after the final `SpiNewData`. `ReqReady` is high the following cycle.
- **Illegal type:** `Error` in the cycle after the handshake, `ReqReady` the cycle after that. No SPI traffic.
- **Reset mid-transfer:** immediate return to IDLE, `SpiInValid` low, no response.

## Test plan
- **Strobe** (type 00, addr 6'h02); SPI model returns 8'h46 → exactly 1 byte 8'h02 sent; `RespValid` pulse; `Status` = 8'h46; `RespData` unchanged.
- **Write** (type 01, addr 6'h11, data 16'hA5C3) → bytes 8'h11, 8'hA5, 8'hC3 sent with `SpiInValid` continuously high; `Status` = first returned byte.
- **Read** (type 10, addr 6'h1D); model returns 8'h40, 8'h12, 8'h34 → header 8'h5D, 8'h00, 8'h00; `RespData` = 16'h1234, `Status` = 8'h40.
- **Stall:** `SpiInRequest` low for 5 cycles between bytes during a write → bytes held stable, no duplication or loss; completes normally.
- **Timeout:** `TIMEOUT` = 16, model stops after the first byte → `Error` pulse, no `RespValid`, `SpiInValid` low; `Status` unchanged; next command succeeds.
- **Illegal and reset:** type 11 → `Error` 1 cycle after handshake, no SPI byte. Reset asserted mid-read → all outputs at reset values while `Reset` is high.

Source files
------------

// File: rtl/cc2420_spi_ctrl_if.sv
// cc2420_spi_ctrl_if: command/response and SPI byte-engine signals of the CC2420 sequencer
interface cc2420_spi_ctrl_if;
  logic ReqValid, ReqReady;
  logic [1:0] ReqType;
  logic [5:0] ReqAddr;
  logic [15:0] ReqWData;
  logic RespValid;
  logic [15:0] RespData;
  logic [7:0] Status;
  logic Error, Busy;
  logic SpiInValid;
  logic [7:0] SpiIn;
  logic SpiInRequest, SpiNewData;
  logic [7:0] SpiOut;
  modport master (
    output ReqValid, ReqType, ReqAddr, ReqWData, SpiInRequest, SpiNewData, SpiOut,
    input ReqReady, RespValid, RespData, Status, Error, Busy, SpiInValid, SpiIn
  );
  modport slave (
    input ReqValid, ReqType, ReqAddr, ReqWData, SpiInRequest, SpiNewData, SpiOut,
    output ReqReady, RespValid, RespData, Status, Error, Busy, SpiInValid, SpiIn
  );
endinterface

// File: rtl/cc2420_spi_ctrl.sv
// cc2420_spi_ctrl: expands strobe/register commands into CC2420 SPI byte frames
module cc2420_spi_ctrl #(
  parameter int TIMEOUT = 1024
) (
  input logic Clock,
  input logic Reset,
  cc2420_spi_ctrl_if.slave bus
);
  localparam int TW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;
  state_t state, nextState;
  logic [1:0] reqType, txCnt, rxCnt, len;
  logic [5:0] addr;
  logic [15:0] wData;
  logic [7:0] statusShadow, dataHi, txByte, status;
  logic [15:0] respData;
  logic [TW-1:0] timer;
  logic isRead, handshake, inValid, accept, newData, lastRx, progress;
  always_comb begin
    isRead = reqType == 2'b10;
    len = reqType == 2'b00 ? 2'd1 : 2'd3;
    handshake = state == IDLE && bus.ReqValid;
    inValid = state == XFER && txCnt < len;
    accept = inValid && bus.SpiInRequest;
    newData = state == XFER && bus.SpiNewData && rxCnt < len;
    lastRx = newData && rxCnt + 2'd1 == len;
    progress = accept || newData;
    txByte = txCnt == 2'd0 ? {1'b0, isRead, addr} : isRead ? 8'h00 : txCnt == 2'd1 ? wData[15:8] : wData[7:0];
    nextState = state == IDLE ? (handshake ? (bus.ReqType == 2'b11 ? ERR : XFER) : IDLE)
              : state == XFER ? (lastRx ? DONE : (!progress && timer == TW'(TIMEOUT - 1)) ? ERR : XFER)
              : IDLE;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= nextState;
  // Status/RespData load on the final received byte so they are already valid during DONE
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      reqType <= '0;
      addr <= '0;
      wData <= '0;
      txCnt <= '0;
      rxCnt <= '0;
      timer <= '0;
      statusShadow <= '0;
      dataHi <= '0;
      status <= '0;
      respData <= '0;
    end else if (handshake) begin
      reqType <= bus.ReqType;
      addr <= bus.ReqAddr;
      wData <= bus.ReqWData;
      txCnt <= '0;
      rxCnt <= '0;
      timer <= '0;
    end else if (state == XFER) begin
      if (accept) txCnt <= txCnt + 2'd1;
      if (newData) rxCnt <= rxCnt + 2'd1;
      timer <= progress ? '0 : timer + TW'(1);
      if (newData && rxCnt == 2'd0) statusShadow <= bus.SpiOut;
      if (newData && rxCnt == 2'd1) dataHi <= bus.SpiOut;
      if (lastRx) status <= rxCnt == 2'd0 ? bus.SpiOut : statusShadow;
      if (lastRx && isRead) respData <= {dataHi, bus.SpiOut};
    end
  assign bus.ReqReady = state == IDLE;
  assign bus.Busy = state != IDLE;
  assign bus.RespValid = state == DONE;
  assign bus.Error = state == ERR;
  assign bus.SpiInValid = inValid;
  assign bus.SpiIn = inValid ? txByte : 8'h00;
  assign bus.Status = status;
  assign bus.RespData = respData;
endmodule
